// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor (PC xor global history) with a tagged direct-mapped BTB.
// Define BP_PERF_CNT_EN to build the resolve/mispredict performance counters.
module gshare_branch_predictor #(
  parameter int unsigned BHT_IDX_W = 8,
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          lookup_pc,
  input  logic                 lookup_is_ctrl,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic                 btb_hit,
  output logic [BHT_IDX_W-1:0] lookup_idx,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_is_jump,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic                 upd_mispredict,
  output logic [31:0]          perf_updates,
  output logic [31:0]          perf_mispredicts
);

  localparam int unsigned PHT_N = 1 << BHT_IDX_W;
  localparam int unsigned BTB_N = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W = 32 - BTB_IDX_W - 2;

  logic [1:0]           pht_q [PHT_N];
  logic [1:0]           pht_d;
  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic [BTB_N-1:0]     btb_vld_q, btb_jmp_q;
  logic [TAG_W-1:0]     btb_tag_q [BTB_N];
  logic [31:0]          btb_tgt_q [BTB_N];

  logic [BTB_IDX_W-1:0] lk_bidx, up_bidx;
  logic [TAG_W-1:0]     lk_tag, up_tag;
  logic                 upd_br, btb_wr;

  // Lookup path: purely combinational off the registered tables
  assign lookup_idx  = lookup_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_q);
  assign lk_bidx     = lookup_pc[BTB_IDX_W+1:2];
  assign lk_tag      = lookup_pc[31:BTB_IDX_W+2];
  assign btb_hit     = btb_vld_q[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
  assign pred_target = btb_hit ? btb_tgt_q[lk_bidx] : 32'd0;
  assign pred_taken  = lookup_is_ctrl && btb_hit &&
                       (btb_jmp_q[lk_bidx] || pht_q[lookup_idx][1]);

  assign upd_br  = upd_valid && !upd_is_jump;
  assign btb_wr  = upd_valid && (upd_is_jump || upd_taken);
  assign up_bidx = upd_pc[BTB_IDX_W+1:2];
  assign up_tag  = upd_pc[31:BTB_IDX_W+2];

  // Saturating counter step and history shift for a resolved conditional branch
  always_comb begin
    pht_d = pht_q[upd_idx];
    ghr_d = ghr_q;
    if (upd_br) begin
      if (upd_taken) begin
        if (pht_d != 2'd3) pht_d = pht_d + 2'd1;
      end else begin
        if (pht_d != 2'd0) pht_d = pht_d - 2'd1;
      end
      ghr_d = GHR_W'({ghr_q, upd_taken});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
      ghr_q <= '0;
    end else begin
      if (upd_br) pht_q[upd_idx] <= pht_d;
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_vld_q <= '0;
      btb_jmp_q <= '0;
    end else if (btb_wr) begin
      btb_vld_q[up_bidx] <= 1'b1;
      btb_jmp_q[up_bidx] <= upd_is_jump;
    end
  end

  // Tag/target payload needs no reset: qualified by the valid bit
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag_q[up_bidx] <= up_tag;
      btb_tgt_q[up_bidx] <= upd_target;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_upd_q, perf_mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_upd_q <= '0;
      perf_mis_q <= '0;
    end else if (upd_valid) begin
      if (perf_upd_q != 32'hFFFF_FFFF) perf_upd_q <= perf_upd_q + 32'd1;
      if (upd_mispredict && (perf_mis_q != 32'hFFFF_FFFF)) perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_updates     = perf_upd_q;
  assign perf_mispredicts = perf_mis_q;

  logic unused_c;
  assign unused_c = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
  assign perf_updates     = 32'd0;
  assign perf_mispredicts = 32'd0;

  logic unused_c;
  assign unused_c = ^{lookup_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor; expected values hand-derived for the default sizes.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        lookup_is_ctrl;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        btb_hit;
  logic [7:0]  lookup_idx;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_idx;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] perf_updates;
  logic [31:0] perf_mispredicts;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_upd, exp_mis;

  gshare_branch_predictor #(.BHT_IDX_W(8), .GHR_W(8), .BTB_IDX_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_pc       (lookup_pc),
    .lookup_is_ctrl  (lookup_is_ctrl),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .btb_hit         (btb_hit),
    .lookup_idx      (lookup_idx),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_idx         (upd_idx),
    .upd_is_jump     (upd_is_jump),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_mispredict  (upd_mispredict),
    .perf_updates    (perf_updates),
    .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic ctrl);
    lookup_pc      = pc;
    lookup_is_ctrl = ctrl;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [7:0] idx, input logic jmp,
                     input logic taken, input logic [31:0] tgt, input logic mis);
    upd_pc         = pc;
    upd_idx        = idx;
    upd_is_jump    = jmp;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = mis;
    upd_valid      = 1'b1;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    lookup_pc = 32'h40; lookup_is_ctrl = 1'b1;
    upd_valid = 1'b0; upd_pc = '0; upd_idx = '0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;

    // Reset state
    check("rst_idx", 32'(lookup_idx), 32'h10);
    check("rst_hit", 32'(btb_hit), 32'd0);
    check("rst_taken", 32'(pred_taken), 32'd0);
    check("rst_target", pred_target, 32'd0);
    check("rst_perf_upd", perf_updates, 32'd0);

    // Train branch 0x40 -> 0x80; GHR 00 -> 01 -> 03 -> 07 -> 0F
    upd(32'h40, 8'h10, 1'b0, 1'b1, 32'h80, 1'b0);
    look(32'h40, 1'b1);
    check("tr1_idx", 32'(lookup_idx), 32'h11);
    check("tr1_hit", 32'(btb_hit), 32'd1);
    check("tr1_target", pred_target, 32'h80);
    check("tr1_taken", 32'(pred_taken), 32'd0);
    upd(32'h40, 8'h11, 1'b0, 1'b1, 32'h80, 1'b0);
    upd(32'h40, 8'h13, 1'b0, 1'b1, 32'h80, 1'b0);
    check("tr3_idx", 32'(lookup_idx), 32'h17);
    check("tr3_taken", 32'(pred_taken), 32'd0);
    upd(32'h40, 8'h1F, 1'b0, 1'b1, 32'h80, 1'b0);
    check("tr4_idx", 32'(lookup_idx), 32'h1F);
    check("tr4_taken", 32'(pred_taken), 32'd1);
    check("tr4_target", pred_target, 32'h80);

    // Saturation on PHT[0x22]; each lookup pc chosen so pc[9:2]^GHR == 0x22
    upd(32'h370, 8'h22, 1'b0, 1'b1, 32'h570, 1'b0);
    upd(32'h368, 8'h22, 1'b0, 1'b1, 32'h568, 1'b0);
    upd(32'h348, 8'h22, 1'b0, 1'b1, 32'h548, 1'b0);
    upd(32'h374, 8'h22, 1'b0, 1'b1, 32'h574, 1'b0);
    upd(32'h374, 8'h22, 1'b0, 1'b1, 32'h574, 1'b0);
    look(32'h374, 1'b1);
    check("sat3_idx", 32'(lookup_idx), 32'h22);
    check("sat3_taken", 32'(pred_taken), 32'd1);
    check("sat3_target", pred_target, 32'h574);
    upd(32'h374, 8'h22, 1'b0, 1'b0, 32'h574, 1'b0);
    look(32'h370, 1'b1);
    check("sat2_idx", 32'(lookup_idx), 32'h22);
    check("sat2_taken", 32'(pred_taken), 32'd1);
    check("sat2_target", pred_target, 32'h570);
    upd(32'h374, 8'h22, 1'b0, 1'b0, 32'h574, 1'b0);
    upd(32'h374, 8'h22, 1'b0, 1'b0, 32'h574, 1'b0);
    look(32'h368, 1'b1);
    check("sat0_idx", 32'(lookup_idx), 32'h22);
    check("sat0_hit", 32'(btb_hit), 32'd1);
    check("sat0_taken", 32'(pred_taken), 32'd0);
    upd(32'h374, 8'h22, 1'b0, 1'b0, 32'h574, 1'b0);
    look(32'h348, 1'b1);
    check("satfloor_idx", 32'(lookup_idx), 32'h22);
    check("satfloor_taken", 32'(pred_taken), 32'd0);

    // JAL 0x100 -> 0x200: GHR stays F0, evicts the 0x40 entry in BTB slot 0
    upd(32'h100, 8'h22, 1'b1, 1'b0, 32'h200, 1'b0);
    check("jal_ghr_idx", 32'(lookup_idx), 32'h22);
    check("jal_pht_kept", 32'(pred_taken), 32'd0);
    look(32'h100, 1'b1);
    check("jal_idx", 32'(lookup_idx), 32'hB0);
    check("jal_taken", 32'(pred_taken), 32'd1);
    check("jal_target", pred_target, 32'h200);
    look(32'h100, 1'b0);
    check("jal_notctrl", 32'(pred_taken), 32'd0);
    look(32'h40, 1'b1);
    check("evict_hit", 32'(btb_hit), 32'd0);
    check("evict_target", pred_target, 32'd0);

    // Aliasing 0x44 / 0x84 in BTB slot 1; GHR F0 -> E1
    upd(32'h44, 8'h05, 1'b0, 1'b1, 32'h444, 1'b0);
    look(32'h84, 1'b1);
    check("alias_hit", 32'(btb_hit), 32'd0);
    check("alias_taken", 32'(pred_taken), 32'd0);
    look(32'h44, 1'b1);
    check("alias_own_hit", 32'(btb_hit), 32'd1);
    check("alias_own_target", pred_target, 32'h444);

    // Same-cycle lookup and update of slot 1: old value now, new value after the edge
    upd_pc = 32'h84; upd_idx = 8'h06; upd_is_jump = 1'b0; upd_taken = 1'b1;
    upd_target = 32'h888; upd_valid = 1'b1;
    #1;
    check("simul_pre_hit", 32'(btb_hit), 32'd1);
    check("simul_pre_target", pred_target, 32'h444);
    check("simul_pre_idx", 32'(lookup_idx), 32'hF0);
    tick();
    upd_valid = 1'b0;
    #1;
    check("simul_post_old", 32'(btb_hit), 32'd0);
    look(32'h84, 1'b1);
    check("simul_post_hit", 32'(btb_hit), 32'd1);
    check("simul_post_target", pred_target, 32'h888);
    check("simul_post_idx", 32'(lookup_idx), 32'hE2);

    // upd_valid low: nothing moves
    upd_pc = 32'h84; upd_idx = 8'h00; upd_taken = 1'b1; upd_target = 32'h999;
    tick();
    look(32'h84, 1'b1);
    check("idle_target", pred_target, 32'h888);
    check("idle_idx", 32'(lookup_idx), 32'hE2);

    // Async reset mid-run, update on the reset edge discarded
    rst = 1'b1;
    #1;
    check("mrst_hit", 32'(btb_hit), 32'd0);
    check("mrst_idx", 32'(lookup_idx), 32'h21);
    check("mrst_perf_upd", perf_updates, 32'd0);
    upd_pc = 32'h84; upd_idx = 8'h21; upd_is_jump = 1'b0; upd_taken = 1'b1;
    upd_target = 32'h888; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mrst_drop_hit", 32'(btb_hit), 32'd0);
    check("mrst_drop_idx", 32'(lookup_idx), 32'h21);

    // Performance counters: 10 updates, 3 flagged mispredicts
`ifdef BP_PERF_CNT_EN
    exp_upd = 32'd10; exp_mis = 32'd3;
`else
    exp_upd = 32'd0;  exp_mis = 32'd0;
`endif
    for (int i = 0; i < 10; i++)
      upd(32'h84, 8'(i), 1'b0, 1'b1, 32'h888, (i % 4) == 1);
    check("perf_updates", perf_updates, exp_upd);
    check("perf_mispredicts", perf_mispredicts, exp_mis);
    upd_valid = 1'b1; upd_mispredict = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("perf_rst_upd", perf_updates, 32'd0);
    check("perf_rst_mis", perf_mispredicts, 32'd0);
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    tick();
    rst = 1'b0;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
